fifo_uart_tx: RTL
=================

# fifo_uart_tx

Serial transmit stage directly downstream of the 8-entry, 8-bit transmit FIFO. Pops one byte at a time through the FIFO read port (`rd`/`empty`/`data_out`), then shifts it out on a single line as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity bit, one stop bit. The FIFO presents `data_out` registered one clock after `rd` is sampled, and this block's fetch sequence is built around that latency.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per serial bit. Legal range is 2..65535.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit after bit 7.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-low.
- `en`  in  1  transmit enable; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_data`  in  8  FIFO `data_out`.
- `fifo_rd`  out  1  FIFO `rd`; single-cycle pop request.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse on the last clock of the stop bit.

## Operation
- States: IDLE, FETCH, WAIT, START, DATA, PARITY, STOP. All outputs are registered or decoded Moore-style from the state.
- IDLE to FETCH when `en`=1 and `fifo_empty`=0; otherwise stay in IDLE.
- FETCH lasts exactly 1 cycle with `fifo_rd`=1. `fifo_rd` is 0 in every other state, so exactly one pop per frame is guaranteed.
- WAIT lasts exactly 1 cycle. `fifo_data` is valid during this cycle and is captured into the 8-bit shift register at the closing edge. Parity is computed as the XOR of the captured byte.
- START: `tx`=0 for `CLKS_PER_BIT` clocks.
- DATA: `tx`=shreg[0]. After each `CLKS_PER_BIT` clocks, shift right and increment the 3-bit bit index. Leave DATA after index 7 completes.
- PARITY (only if `PARITY_EN`=1): `tx`=even parity for `CLKS_PER_BIT` clocks.
- STOP: `tx`=1 for `CLKS_PER_BIT` clocks. `tx_done`=1 on the final clock. Then go to IDLE.
- `en` deasserted mid-frame: the current frame completes and no new fetch occurs.
- `fifo_empty` is ignored outside IDLE.
- Reset mid-frame: the frame is aborted and the popped byte is lost. This is intended behaviour.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1, wraps to 0 on every bit boundary, and is cleared on entry to START.

## Timing
- Reset values: `tx`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0, state IDLE, counters 0, shreg 0.
- From the IDLE cycle with `en`, !`fifo_empty` to the first `tx`=0 cycle: 3 clocks (IDLE→FETCH→WAIT→START).
- Frame length from the first START cycle to the last STOP cycle: (10+`PARITY_EN`)·`CLKS_PER_BIT` clocks.
- Back-to-back frames: `tx` stays high for exactly `CLKS_PER_BIT`+3 clocks between start bits. This is the stop bit plus the IDLE, FETCH and WAIT cycles.
- Minimum spacing between `fifo_rd` pulses: (10+`PARITY_EN`)·`CLKS_PER_BIT`+3 clocks.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants (3-bit),
  - `DATA_BITS`=8,
  - `FRAME_BITS` = 10 + `PARITY_EN`.
- One sub-module, `baud_tick`: a parameterised `CLKS_PER_BIT` counter with a synchronous clear, emitting a one-cycle `tick` on the last clock of each bit. The FSM, shift register and parity logic stay in the top level.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `en`=1 and `fifo_empty`=0 → `tx`=1, `fifo_rd`=0, `busy`=0 throughout. The first `fifo_rd` pulse follows 1 cycle after release.
- Single byte, `CLKS_PER_BIT`=4, `PARITY_EN`=0: push 0xA5 → one `fifo_rd` pulse. `tx` shows 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks. `tx_done` pulses at clock 40 of the frame.
- Parity, `CLKS_PER_BIT`=4, `PARITY_EN`=1:
  - 0xA5 → parity bit 0 and a 44-clock frame;
  - 0x07 → parity bit 1.
- Back-to-back: push 0x00, 0xFF, 0x3C → exactly 3 `fifo_rd` pulses spaced 43 clocks apart. The idle-high gap is 7 clocks, and `fifo_empty` is 1 after the third pop.
- Enable gating: deassert `en` during DATA of the first of 2 queued bytes → the first frame completes, `busy` falls, and no second `fifo_rd` occurs. Reasserting `en` starts the second frame 3 clocks later.
- Reset mid-frame: assert `rst` during bit 3 → `tx`=1 and `busy`=0 on the next edge. After release, the next queued byte is sent intact and the aborted byte is not resent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// frame geometry and the parity helper.
package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int BASE_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_e;

  // Serial bits per frame: start + data + stop, plus the optional parity bit.
  function automatic int frame_bits(input int parity_en);
    return BASE_FRAME_BITS + parity_en;
  endfunction

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while not cleared and flags
// the last clock of each bit (tick) and the clock before it (pre_tick).
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_r;

  // Bit-period counter, wrapping on every bit boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST_CNT) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick     = !clr && (cnt_r == LAST_CNT);
  assign pre_tick = !clr && (cnt_r == PRE_LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from the TX FIFO read port: pops one byte per frame
// and shifts out start, 8 data bits LSB first, optional even parity, stop.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_e               state_r, state_s;
  logic [DATA_BITS-1:0] shreg_r, shreg_s;
  logic [2:0]           bit_idx_r, bit_idx_s;
  logic                 parity_r, parity_s;
  logic                 tx_r, fifo_rd_r, busy_r, tx_done_r;
  logic                 tx_s;
  logic                 tick_s, pre_tick_s, baud_clr_s;

  // The bit timer only runs while a frame is on the line, so it is at 0 on entry to START.
  assign baud_clr_s = (state_r == ST_IDLE) || (state_r == ST_FETCH) || (state_r == ST_WAIT);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr_s),
    .tick    (tick_s),
    .pre_tick(pre_tick_s)
  );

  // Next-state, shift register and parity capture.
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    bit_idx_s = bit_idx_r;
    parity_s  = parity_r;
    case (state_r)
      ST_IDLE: begin
        if (en && !fifo_empty) state_s = ST_FETCH;
        else                   state_s = ST_IDLE;
      end
      ST_FETCH: state_s = ST_WAIT;
      ST_WAIT: begin
        // FIFO data_out is valid one clock after the pop request.
        state_s   = ST_START;
        shreg_s   = fifo_data;
        parity_s  = even_parity(fifo_data);
        bit_idx_s = 3'd0;
      end
      ST_START: begin
        if (tick_s) state_s = ST_DATA;
        else        state_s = ST_START;
      end
      ST_DATA: begin
        if (tick_s) begin
          shreg_s   = {1'b0, shreg_r[DATA_BITS-1:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == LAST_BIT) state_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          else                       state_s = ST_DATA;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) state_s = ST_STOP;
        else        state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (tick_s) state_s = ST_IDLE;
        else        state_s = ST_STOP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Line level for the cycle about to start, decoded from the next state.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shreg_s[0];
      ST_PARITY: tx_s = parity_s;
      default:   tx_s = 1'b1;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      shreg_r   <= '0;
      bit_idx_r <= 3'd0;
      parity_r  <= 1'b0;
      tx_r      <= 1'b1;
      fifo_rd_r <= 1'b0;
      busy_r    <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      bit_idx_r <= bit_idx_s;
      parity_r  <= parity_s;
      tx_r      <= tx_s;
      fifo_rd_r <= (state_s == ST_FETCH);
      busy_r    <= (state_s != ST_IDLE);
      // Set one clock early so the pulse lands on the last stop-bit clock.
      tx_done_r <= (state_r == ST_STOP) && pre_tick_s;
    end
  end

  assign tx      = tx_r;
  assign fifo_rd = fifo_rd_r;
  assign busy    = busy_r;
  assign tx_done = tx_done_r;

endmodule
